hrange_reduce: RTL and testbench

HRANGE_REDUCE -- requirements
Module: hrange_reduce

---
 rtl/hrange_reduce.sv | 135 +++++++++++++
 tb/tb_hrange_reduce.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hrange_reduce.sv
// hrange_reduce -- reduces the stream from an hrange generator to a sum and a count.
//
// Purpose:
//   After _start, every item the upstream generator presents (src_valid) is
//   accepted: src_0 is added to a running sum and a running count is bumped.
//   When the generator signals src_done, the sum and count are published on
//   _0/_1 with _valid=1 and _done=1 one cycle later. They are held until the
//   consumer takes them with _ready.
//
// Ports:
//   _clock     in   system clock, all state on its rising edge
//   _reset     in   synchronous active-high reset, beats every other input
//   _start     in   begin a new reduction (only looked at in IDLE)
//   _ready     in   consumer accepts the published result
//   src_valid  in   upstream item valid
//   src_done   in   upstream stream finished
//   src_0      in   upstream first value (summed)
//   src_1      in   upstream second value (unused)
//   src_ready  out  upstream may present items (high only in COLLECT)
//   _valid     out  result valid
//   _done      out  reduction complete (sticky until the next _start)
//   _0         out  sum of accepted src_0 values, wraps modulo 2^32
//   _1         out  count of accepted items, wraps modulo 2^32
//   dbg_state  out  current FSM state (IDLE=0, COLLECT=1, EMIT=2)
//
// Handshake semantics:
//   Upstream: an item transfers on a rising edge where src_ready=1 and
//   src_valid=1. src_done is only honoured while src_ready=1, and an item
//   presented in the same cycle as src_done still counts.
//   Downstream: the result transfers on a rising edge where _valid=1 and
//   _ready=1. While _valid=1 and _ready=0, _valid, _done, _0 and _1 are held
//   stable.

module hrange_reduce (
    input  logic               _clock,
    input  logic               _reset,
    input  logic               _start,
    input  logic               _ready,
    input  logic               src_valid,
    input  logic               src_done,
    input  logic signed [31:0] src_0,
    input  logic signed [31:0] src_1,
    output logic               src_ready,
    output logic               _valid,
    output logic               _done,
    output logic signed [31:0] _0,
    output logic signed [31:0] _1,
    output logic [1:0]         dbg_state
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] EMIT    = 2'd2;

    logic [1:0]         state;
    logic signed [31:0] sum;
    logic [31:0]        count;

    logic               accept;
    logic signed [31:0] sum_next;
    logic [31:0]        count_next;

    // The second generator output carries nothing this reduction needs.
    logic unused_src_1;
    assign unused_src_1 = ^src_1;

    assign src_ready = (state == COLLECT);
    assign dbg_state = state;

    // The running totals with the current item folded in. src_done uses these
    // so an item arriving in the same cycle as src_done is not lost.
    always_comb begin
        accept     = 1'b0;
        sum_next   = sum;
        count_next = count;
        if (state == COLLECT && src_valid) begin
            accept     = 1'b1;
            sum_next   = sum + src_0;
            count_next = count + 32'd1;
        end
    end

    always_ff @(posedge _clock) begin
        if (_reset) begin
            state  <= IDLE;
            sum    <= 32'sd0;
            count  <= 32'd0;
            _valid <= 1'b0;
            _done  <= 1'b0;
            _0     <= 32'sd0;
            _1     <= 32'sd0;
        end else begin
            case (state)
                IDLE: begin
                    if (_start) begin
                        sum    <= 32'sd0;
                        count  <= 32'd0;
                        _valid <= 1'b0;
                        _done  <= 1'b0;
                        state  <= COLLECT;
                    end
                end

                COLLECT: begin
                    if (accept) begin
                        sum   <= sum_next;
                        count <= count_next;
                    end
                    if (src_done) begin
                        _0     <= sum_next;
                        _1     <= count_next;
                        _valid <= 1'b1;
                        _done  <= 1'b1;
                        state  <= EMIT;
                    end
                end

                EMIT: begin
                    // _done and the result stay put after the transfer so a
                    // late observer can still read the last reduction.
                    if (_ready) begin
                        _valid <= 1'b0;
                        state  <= IDLE;
                    end
                end

                default: begin
                    state  <= IDLE;
                    _valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hrange_reduce.sv
// tb_hrange_reduce -- self-checking bench for hrange_reduce.
//
// Purpose:
//   The driver streams item lists into the block. For each run it computes the
//   expected {count, sum} and pushes it onto exp_q. Each scenario task pops the
//   entry and compares it with the published result.
//
// Ports: none (top-level bench).

module tb_hrange_reduce;

    logic               _clock;
    logic               _reset;
    logic               _start;
    logic               _ready;
    logic               src_valid;
    logic               src_done;
    logic signed [31:0] src_0;
    logic signed [31:0] src_1;
    logic               src_ready;
    logic               _valid;
    logic               _done;
    logic signed [31:0] _0;
    logic signed [31:0] _1;
    logic [1:0]         dbg_state;

    logic [63:0] exp_q[$];     // {count, sum}
    logic [31:0] stim_q[$];    // items for the next run

    int n_cmp;
    int n_err;

    hrange_reduce dut (
        ._clock    (_clock),
        ._reset    (_reset),
        ._start    (_start),
        ._ready    (_ready),
        .src_valid (src_valid),
        .src_done  (src_done),
        .src_0     (src_0),
        .src_1     (src_1),
        .src_ready (src_ready),
        ._valid    (_valid),
        ._done     (_done),
        ._0        (_0),
        ._1        (_1),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial _clock = 1'b0;
    always #5 _clock = ~_clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no end want end");
        $fatal(1, "watchdog");
    end

    // Advance one rising edge; inputs are driven and outputs sampled 1 time
    // unit after it, well away from the edge.
    task automatic tick();
        @(posedge _clock);
        #1;
    endtask

    // ---------------- driver ----------------
    // Starts a run, streams stim_q, and ends with src_done. When done_last
    // is set, src_done goes with the last item. When glitch_start is set,
    // _start stays high through collection, and the block must ignore it.
    // The driver returns 1 time unit after the edge that sampled src_done.
    task automatic drive_run(input bit done_last, input logic ready_val,
                             input bit glitch_start);
        logic [31:0] s;
        logic [31:0] c;
        int n;
        s = 32'd0;
        c = 32'd0;
        n = stim_q.size();
        _start = 1'b1;
        tick();
        _start = glitch_start;
        _ready = ready_val;
        for (int i = 0; i < n; i++) begin
            src_valid = 1'b1;
            src_0     = stim_q[i];
            src_1     = $urandom;
            src_done  = (done_last && i == n - 1);
            s = s + stim_q[i];
            c = c + 32'd1;
            tick();
        end
        if (!(done_last && n > 0)) begin
            src_valid = 1'b0;
            src_0     = $urandom;
            src_done  = 1'b1;
            tick();
        end
        exp_q.push_back({c, s});
        src_valid = 1'b0;
        src_done  = 1'b0;
        _start    = 1'b0;
        stim_q.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        _reset = 1'b1; _start = 1'b1; src_valid = 1'b1; src_done = 1'b1;
        _ready = 1'b1; src_0 = 32'sd7; src_1 = 32'sd0;
        tick();
        tick();
        _reset = 1'b0; _start = 1'b0; src_valid = 1'b0; src_done = 1'b0;
        n_cmp++;
        if (_valid !== 1'b0 || _done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: got valid=%0b done=%0b want 0 0", _valid, _done);
        end
        n_cmp++;
        if (_0 !== 32'sd0 || _1 !== 32'sd0) begin
            n_err++;
            $display("FAIL reset_data: got _0=%0d _1=%0d want 0 0", _0, _1);
        end
        n_cmp++;
        if (src_ready !== 1'b0 || dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL reset_state: got src_ready=%0b state=%0d want 0 0", src_ready, dbg_state);
        end
        // Upstream activity in IDLE must be ignored.
        src_valid = 1'b1; src_done = 1'b1; src_0 = 32'sd9;
        tick();
        tick();
        src_valid = 1'b0; src_done = 1'b0;
        n_cmp++;
        if (_valid !== 1'b0 || _done !== 1'b0 || _1 !== 32'sd0) begin
            n_err++;
            $display("FAIL idle_ignore: got valid=%0b done=%0b _1=%0d want 0 0 0", _valid, _done, _1);
        end
    endtask

    task automatic test_basic();
        logic [63:0] e;
        for (int i = 0; i < 5; i++) stim_q.push_back(32'(2 * i));
        drive_run(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (_valid !== 1'b1 || _done !== 1'b1) begin
            n_err++;
            $display("FAIL basic_latency: got valid=%0b done=%0b want 1 1", _valid, _done);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (_0 !== e[31:0] || _1 !== e[63:32] || e[31:0] !== 32'd20) begin
            n_err++;
            $display("FAIL basic_result: got _0=%0d _1=%0d want %0d %0d", _0, _1, e[31:0], e[63:32]);
        end
        tick();
        n_cmp++;
        if (_valid !== 1'b0 || _done !== 1'b1 || _0 !== 32'sd20) begin
            n_err++;
            $display("FAIL basic_release: got valid=%0b done=%0b _0=%0d want 0 1 20", _valid, _done, _0);
        end
    endtask

    task automatic test_same_cycle_done();
        logic [63:0] e;
        for (int i = 0; i < 5; i++) stim_q.push_back(32'(2 * i));
        drive_run(1'b1, 1'b1, 1'b1);
        e = exp_q.pop_front();
        n_cmp++;
        if (_valid !== 1'b1 || _0 !== e[31:0] || _1 !== e[63:32]) begin
            n_err++;
            $display("FAIL same_cycle: got valid=%0b _0=%0d _1=%0d want 1 %0d %0d", _valid, _0, _1, e[31:0], e[63:32]);
        end
        tick();
    endtask

    task automatic test_hold();
        logic [63:0] e;
        for (int i = 0; i < 5; i++) stim_q.push_back(32'(2 * i));
        drive_run(1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (_valid !== 1'b1 || _done !== 1'b1 || _0 !== e[31:0] || _1 !== e[63:32]) begin
                n_err++;
                $display("FAIL hold_%0d: got valid=%0b done=%0b _0=%0d _1=%0d want 1 1 %0d %0d",
                         k, _valid, _done, _0, _1, e[31:0], e[63:32]);
            end
            _start = 1'b1;   // must be ignored in EMIT
            tick();
        end
        _start = 1'b0;
        _ready = 1'b1;
        tick();
        n_cmp++;
        if (_valid !== 1'b0 || _done !== 1'b1 || _1 !== e[63:32]) begin
            n_err++;
            $display("FAIL hold_release: got valid=%0b done=%0b _1=%0d want 0 1 %0d", _valid, _done, _1, e[63:32]);
        end
    endtask

    task automatic test_restart_and_empty();
        logic [63:0] e;
        // _done is still 1 from the previous run; _start must clear it.
        _start = 1'b1;
        _ready = 1'b1;
        tick();
        _start = 1'b0;
        n_cmp++;
        if (_done !== 1'b0 || src_ready !== 1'b1) begin
            n_err++;
            $display("FAIL restart: got done=%0b src_ready=%0b want 0 1", _done, src_ready);
        end
        src_done = 1'b1;
        tick();
        src_done = 1'b0;
        n_cmp++;
        if (_valid !== 1'b1 || _0 !== 32'sd0 || _1 !== 32'sd0) begin
            n_err++;
            $display("FAIL empty: got valid=%0b _0=%0d _1=%0d want 1 0 0", _valid, _0, _1);
        end
        tick();
    endtask

    task automatic test_wrap();
        logic [63:0] e;
        stim_q.push_back(32'h7FFF_FFFF);
        stim_q.push_back(32'h0000_0001);
        drive_run(1'b0, 1'b1, 1'b0);
        e = exp_q.pop_front();
        n_cmp++;
        if (_0 !== e[31:0] || _0 !== 32'sh8000_0000 || _1 !== 32'sd2) begin
            n_err++;
            $display("FAIL wrap: got _0=%0d _1=%0d want -2147483648 2", _0, _1);
        end
        tick();
    endtask

    task automatic test_reset_mid_collect();
        logic [63:0] e;
        _start = 1'b1;
        tick();
        _start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            src_valid = 1'b1;
            src_0 = 32'(100 + i);
            tick();
        end
        // Reset beats src_done in the same cycle.
        _reset = 1'b1; src_done = 1'b1;
        tick();
        _reset = 1'b0; src_done = 1'b0; src_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (_valid !== 1'b0 || _done !== 1'b0 || _0 !== 32'sd0) begin
                n_err++;
                $display("FAIL reset_mid_%0d: got valid=%0b done=%0b _0=%0d want 0 0 0", k, _valid, _done, _0);
            end
            tick();
        end
        stim_q.push_back(32'd5);
        stim_q.push_back(32'd5);
        drive_run(1'b0, 1'b1, 1'b0);
        e = exp_q.pop_front();
        n_cmp++;
        if (_valid !== 1'b1 || _0 !== e[31:0] || _1 !== e[63:32] || _0 !== 32'sd10) begin
            n_err++;
            $display("FAIL reset_fresh: got valid=%0b _0=%0d _1=%0d want 1 10 2", _valid, _0, _1);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [63:0] e;
        int n;
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(0, 8);
            for (int i = 0; i < n; i++) stim_q.push_back($urandom);
            drive_run(r[0], 1'b1, 1'b0);
            e = exp_q.pop_front();
            n_cmp++;
            if (_valid !== 1'b1 || _0 !== e[31:0] || _1 !== e[63:32]) begin
                n_err++;
                $display("FAIL b2b_%0d: got valid=%0b _0=%0h _1=%0d want 1 %0h %0d",
                         r, _valid, _0, _1, e[31:0], e[63:32]);
            end
            tick();
        end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        _reset = 1'b1; _start = 1'b0; _ready = 1'b0;
        src_valid = 1'b0; src_done = 1'b0; src_0 = 32'sd0; src_1 = 32'sd0;
        test_reset();
        test_basic();
        test_same_cycle_done();
        test_hold();
        test_restart_and_empty();
        test_wrap();
        test_reset_mid_collect();
        test_back_to_back();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
